// File: rtl/turn_timer.sv
// turn_timer: per-turn countdown with its own tick prescaler and start/stop handshake.
// Optional feature: define TURN_TIMER_PAUSE_EN to add a PAUSE input that freezes the countdown.
module turn_timer #(
    parameter int TICK_DIV = 50,
    parameter int LIMIT_W  = 4
) (
    input  logic               CLKT,
    input  logic               R,
    input  logic               START,
    input  logic [LIMIT_W-1:0] LIMIT,
    input  logic               STOP,
`ifdef TURN_TIMER_PAUSE_EN
    input  logic               PAUSE,
`endif
    output logic               BUSY,
    output logic [LIMIT_W-1:0] TEMPO,
    output logic               end_time,
    output logic               stopped
);

    localparam int                PCNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(TICK_DIV - 1);
    localparam logic [LIMIT_W-1:0] ONE     = LIMIT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PCNT_W-1:0]  pcnt;
    logic [PCNT_W-1:0]  pcnt_nxt;
    logic [LIMIT_W-1:0] tempo_nxt;
    logic               end_nxt;
    logic               stopped_nxt;
    logic               frozen;
    logic               tick;

`ifdef TURN_TIMER_PAUSE_EN
    assign frozen = PAUSE;
`else
    assign frozen = 1'b0;
`endif

    assign tick = (state == RUN) && !frozen && (pcnt == PCNT_MAX);
    assign BUSY = (state == RUN);

    always_ff @(posedge CLKT or negedge R) begin
        if (!R) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // STOP outranks the final tick, so expiry is only taken when no stop is pending.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (START && (LIMIT != '0)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (STOP) begin
                    state_nxt = IDLE;
                end else if (tick && (TEMPO <= ONE)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pcnt_nxt    = pcnt;
        tempo_nxt   = TEMPO;
        end_nxt     = 1'b0;
        stopped_nxt = 1'b0;
        case (state)
            IDLE: begin
                pcnt_nxt = '0;
                if (START) begin
                    tempo_nxt = LIMIT;
                    end_nxt   = (LIMIT == '0);
                end
            end
            RUN: begin
                if (STOP) begin
                    pcnt_nxt    = '0;
                    stopped_nxt = 1'b1;
                end else if (!frozen) begin
                    pcnt_nxt = (pcnt == PCNT_MAX) ? '0 : pcnt + PCNT_W'(1);
                    if (tick) begin
                        if (TEMPO > ONE) begin
                            tempo_nxt = TEMPO - ONE;
                        end else begin
                            tempo_nxt = '0;
                            end_nxt   = 1'b1;
                        end
                    end
                end
            end
            default: begin
                pcnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge CLKT or negedge R) begin
        if (!R) begin
            pcnt     <= '0;
            TEMPO    <= '0;
            end_time <= 1'b0;
            stopped  <= 1'b0;
        end else begin
            pcnt     <= pcnt_nxt;
            TEMPO    <= tempo_nxt;
            end_time <= end_nxt;
            stopped  <= stopped_nxt;
        end
    end

endmodule

// File: tb/tb_turn_timer.sv
// tb_turn_timer: directed and random checks of turn_timer against an elapsed-time model.
module tb_turn_timer;

    localparam int TD = 4;

    logic       CLKT;
    logic       R;
    logic       START;
    logic [3:0] LIMIT;
    logic       STOP;
    logic       pause_sig;
    logic       BUSY;
    logic [3:0] TEMPO;
    logic       end_time;
    logic       stopped;

    int total = 0;
    int bad   = 0;

    // Reference model: remaining = budget - (unpaused edges since arm) / TD.
    bit m_busy    = 0;
    int m_elapsed = 0;
    int m_limit   = 0;
    int exp_tempo = 0;
    bit exp_end   = 0;
    bit exp_stop  = 0;

`ifdef TURN_TIMER_PAUSE_EN
    localparam bit HAS_PAUSE = 1'b1;
`else
    localparam bit HAS_PAUSE = 1'b0;
`endif

    turn_timer #(
        .TICK_DIV(TD),
        .LIMIT_W (4)
    ) dut (
        .CLKT    (CLKT),
        .R       (R),
        .START   (START),
        .LIMIT   (LIMIT),
        .STOP    (STOP),
`ifdef TURN_TIMER_PAUSE_EN
        .PAUSE   (pause_sig),
`endif
        .BUSY    (BUSY),
        .TEMPO   (TEMPO),
        .end_time(end_time),
        .stopped (stopped)
    );

    initial CLKT = 1'b0;
    always #5 CLKT = ~CLKT;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag);
        check_val({tag, "/BUSY"},     8'(BUSY),     8'(m_busy));
        check_val({tag, "/TEMPO"},    8'(TEMPO),    8'(exp_tempo));
        check_val({tag, "/end_time"}, 8'(end_time), 8'(exp_end));
        check_val({tag, "/stopped"},  8'(stopped),  8'(exp_stop));
    endtask

    task automatic model_reset();
        m_busy    = 0;
        m_elapsed = 0;
        m_limit   = 0;
        exp_tempo = 0;
        exp_end   = 0;
        exp_stop  = 0;
    endtask

    task automatic model_edge(input bit st, input bit sp, input int lim, input bit pa);
        exp_end  = 0;
        exp_stop = 0;
        if (!m_busy) begin
            if (st) begin
                exp_tempo = lim;
                if (lim == 0) begin
                    exp_end = 1;
                end else begin
                    m_busy    = 1;
                    m_elapsed = 0;
                    m_limit   = lim;
                end
            end
        end else if (sp) begin
            exp_stop = 1;
            m_busy   = 0;
        end else if (!(pa && HAS_PAUSE)) begin
            m_elapsed++;
            exp_tempo = m_limit - m_elapsed / TD;
            if (exp_tempo == 0) begin
                exp_end = 1;
                m_busy  = 0;
            end
        end
    endtask

    // One clock edge: drive inputs, advance the model, sample 1ns after the edge.
    task automatic apply_stimulus(input string tag, input bit st, input bit sp,
                                  input logic [3:0] lim, input bit pa);
        START     = st;
        STOP      = sp;
        LIMIT     = lim;
        pause_sig = pa;
        @(posedge CLKT);
        model_edge(st, sp, int'(lim), pa);
        #1;
        check_output(tag);
    endtask

    initial begin
        R         = 1'b0;
        START     = 1'b0;
        STOP      = 1'b0;
        LIMIT     = 4'd0;
        pause_sig = 1'b0;
        model_reset();
        #1;
        check_output("por");
        @(negedge CLKT);
        R = 1'b1;
        apply_stimulus("idle", 0, 0, 4'd0, 0);

        // Asynchronous reset in the middle of a run with TEMPO=5.
        apply_stimulus("rst_arm", 1, 0, 4'd5, 0);
        apply_stimulus("rst_run", 0, 0, 4'd0, 0);
        check_val("rst_pre_tempo", 8'(TEMPO), 8'd5);
        #2;
        R = 1'b0;
        #1;
        model_reset();
        check_output("rst_async");
        check_val("rst_async_tempo", 8'(TEMPO), 8'd0);
        @(posedge CLKT);
        #1;
        check_output("rst_held");
        #2;
        R = 1'b1;
        for (int i = 0; i < 3; i++) apply_stimulus("rst_after", 0, 0, 4'd0, 0);

        // Full expiry with LIMIT=3.
        apply_stimulus("exp_e0", 1, 0, 4'd3, 0);
        check_val("exp_e0_tempo", 8'(TEMPO), 8'd3);
        for (int e = 1; e < 12; e++) begin
            apply_stimulus("exp_run", 0, 0, 4'd0, 0);
            if (e == 4) check_val("exp_e4_tempo", 8'(TEMPO), 8'd2);
            if (e == 8) check_val("exp_e8_tempo", 8'(TEMPO), 8'd1);
        end
        apply_stimulus("exp_e12", 0, 0, 4'd0, 0);
        check_val("exp_e12_end", 8'(end_time), 8'd1);
        check_val("exp_e12_busy", 8'(BUSY), 8'd0);
        check_val("exp_e12_tempo", 8'(TEMPO), 8'd0);
        apply_stimulus("exp_e13", 0, 0, 4'd0, 0);
        check_val("exp_e13_end", 8'(end_time), 8'd0);

        // Early stop with LIMIT=9 at edge 10.
        apply_stimulus("stop_e0", 1, 0, 4'd9, 0);
        for (int e = 1; e < 10; e++) apply_stimulus("stop_run", 0, 0, 4'd0, 0);
        apply_stimulus("stop_e10", 0, 1, 4'd0, 0);
        check_val("stop_pulse", 8'(stopped), 8'd1);
        check_val("stop_tempo", 8'(TEMPO), 8'd7);
        for (int i = 0; i < 6; i++) apply_stimulus("stop_after", 0, 0, 4'd0, 0);
        check_val("stop_hold_tempo", 8'(TEMPO), 8'd7);

        // Zero budget, START+STOP in IDLE, START during RUN.
        apply_stimulus("zero", 1, 0, 4'd0, 0);
        check_val("zero_end", 8'(end_time), 8'd1);
        check_val("zero_busy", 8'(BUSY), 8'd0);
        apply_stimulus("zero_after", 0, 0, 4'd0, 0);
        apply_stimulus("both_idle", 1, 1, 4'd2, 0);
        check_val("both_busy", 8'(BUSY), 8'd1);
        apply_stimulus("rearm", 1, 0, 4'd9, 0);
        check_val("rearm_tempo", 8'(TEMPO), 8'd2);
        for (int i = 0; i < 8; i++) apply_stimulus("rearm_run", 0, 0, 4'd0, 0);

        // STOP on the final tick wins; then back-to-back start.
        apply_stimulus("fin_e0", 1, 0, 4'd1, 0);
        for (int e = 1; e < 4; e++) apply_stimulus("fin_run", 0, 0, 4'd0, 0);
        apply_stimulus("fin_e4", 0, 1, 4'd0, 0);
        check_val("fin_stopped", 8'(stopped), 8'd1);
        check_val("fin_end", 8'(end_time), 8'd0);
        check_val("fin_tempo", 8'(TEMPO), 8'd1);
        apply_stimulus("b2b", 1, 0, 4'd2, 0);
        check_val("b2b_busy", 8'(BUSY), 8'd1);
        for (int i = 0; i < 8; i++) apply_stimulus("b2b_run", 0, 0, 4'd0, 0);

`ifdef TURN_TIMER_PAUSE_EN
        // PAUSE over edges 2..11 shifts expiry from edge 8 to edge 18.
        apply_stimulus("pz_e0", 1, 0, 4'd2, 0);
        for (int e = 1; e < 18; e++) begin
            apply_stimulus("pz_run", 0, 0, 4'd0, (e >= 2 && e <= 11));
            if (e == 8) check_val("pz_e8_busy", 8'(BUSY), 8'd1);
        end
        apply_stimulus("pz_e18", 0, 0, 4'd0, 0);
        check_val("pz_e18_end", 8'(end_time), 8'd1);
        apply_stimulus("pz_idle", 1, 0, 4'd0, 1);
        check_val("pz_idle_end", 8'(end_time), 8'd1);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] lim;
            lim = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
            apply_stimulus("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0),
                           lim, HAS_PAUSE && ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/turn_timer.md
# turn_timer

Per-turn response countdown timer for the Genius game datapath. The game FSM arms it when the player's turn begins; it loads a tick budget, generates its own time base from the system clock, and counts down. It reports either that the player answered in time (`stopped`) or that the budget ran out (`end_time`). It is the arming/consuming counterpart to the up-counting time counter: the countdown is owned here and driven by explicit start/stop requests.

## Interface

Parameters:
- `TICK_DIV`, default 50: system clock cycles per time tick; legal range ≥ 2.
- `LIMIT_W`, default 4: width of the tick budget and of `TEMPO`.

Ports (clock and reset first):
- `CLKT`, in, 1: system clock; all state changes on the rising edge.
- `R`, in, 1: reset, asynchronous, active-low.
- `START`, in, 1: arm request; sampled each edge.
- `LIMIT`, in, `LIMIT_W`: tick budget, captured at an accepted `START`.
- `STOP`, in, 1: player responded; sampled each edge.
- `BUSY`, out, 1: countdown in progress.
- `TEMPO`, out, `LIMIT_W`: remaining ticks.
- `end_time`, out, 1: one-cycle timeout pulse.
- `stopped`, out, 1: one-cycle pulse marking an accepted stop.

## Operation

- State machine has two states, IDLE and RUN. `BUSY` = (state == RUN), registered.
- Prescaler `pcnt` (width clog2(`TICK_DIV`)):
  - In RUN it counts 0..`TICK_DIV`-1 and wraps to 0.
  - `tick` = RUN && `pcnt` == `TICK_DIV`-1.
  - Held at 0 in IDLE; cleared on every accepted `START`.
- IDLE:
  - `START`=1 and `LIMIT`≠0: `TEMPO`←`LIMIT`, `pcnt`←0, go to RUN.
  - `START`=1 and `LIMIT`=0: `TEMPO`←0, `end_time` pulses, stay in IDLE.
  - `STOP` is ignored in IDLE. If `START` and `STOP` arrive together, `START` is accepted.
- RUN:
  - `STOP`=1: `stopped` pulses, go to IDLE. `TEMPO` holds the remaining value for scoring.
  - Otherwise, `tick` with `TEMPO`>1: `TEMPO`←`TEMPO`-1.
  - Otherwise, `tick` with `TEMPO`==1: `TEMPO`←0, `end_time` pulses, go to IDLE.
  - `START` is ignored in RUN; no re-arm.
- Simultaneous `STOP` and final tick: `STOP` wins. `stopped` pulses, `end_time` stays 0, and `TEMPO` holds 1.
- `end_time` and `stopped` are never high in the same cycle.
- Arithmetic: `TEMPO` never wraps below 0; it is unsigned `LIMIT_W` bits.

## Timing

- Reset (`R`=0, asynchronous) values:
  - state IDLE, `pcnt`=0
  - `TEMPO`=0, `BUSY`=0, `end_time`=0, `stopped`=0
- Release of reset takes effect on the next rising edge.
- `START` accepted at edge k: `BUSY`=1 and `TEMPO`=`LIMIT` after edge k.
- First decrement occurs at edge k+`TICK_DIV`. The nth decrement occurs at edge k+n·`TICK_DIV`.
- Expiry: `end_time`=1 and `BUSY`=0 after edge k+`LIMIT`·`TICK_DIV`. `end_time` returns to 0 one cycle later.
- `LIMIT`=0: `end_time`=1 after edge k; `BUSY` stays 0.
- `STOP` at edge j in RUN: `stopped`=1 and `BUSY`=0 after edge j, for exactly one cycle.
- A new `START` is accepted at the edge after a pulse (back-to-back turns, no dead cycle).
- Reset asserted mid-RUN forces all reset values immediately; no pulse is emitted.

## Configuration

- Macro `TURN_TIMER_PAUSE_EN`.
- Defined:
  - Adds input port `PAUSE` (1 bit).
  - While `PAUSE`=1 in RUN, `pcnt` and `TEMPO` freeze, and `tick` is suppressed.
  - `STOP` is still honoured while paused.
  - Releasing `PAUSE` resumes counting from the frozen `pcnt`.
  - `PAUSE` has no effect in IDLE.
- Not defined:
  - No `PAUSE` port.
  - Countdown is never frozen; behaviour is exactly as above.

## Test plan

All scenarios use `TICK_DIV`=4 and `LIMIT_W`=4.

- Reset: hold `R`=0 mid-RUN with `TEMPO`=5 → `TEMPO`=0, `BUSY`=0 and both pulses 0 immediately; no pulse after release.
- Full expiry: `START` with `LIMIT`=3 at edge 0 → `TEMPO` is 3, 2, 1 after edges 0, 4, 8. After edge 12: `TEMPO`=0, `end_time`=1 for one cycle, `BUSY`=0.
- Early stop: `LIMIT`=9, `STOP` at edge 10 → `stopped`=1 for one cycle, `TEMPO`=7 held, `end_time` never asserts.
- Zero budget and collisions:
  - `LIMIT`=0 → `end_time` the cycle after `START`, `BUSY` never 1.
  - `START` and `STOP` together in IDLE → run starts.
  - `START` during RUN → `TEMPO` unaffected.
- Stop on final tick: `LIMIT`=1, `STOP` at edge 4 → `stopped`=1, `end_time`=0, `TEMPO`=1.
- With `TURN_TIMER_PAUSE_EN`: `LIMIT`=2, `PAUSE` high for edges 2..11 → expiry moves from edge 8 to edge 18.
